// File: rtl/nios_system_pio_gen.sv
// Avalon-MM general-purpose PIO: output data register with set/clear aliases,
// per-bit direction, synchronized inputs with edge capture and a masked level interrupt.
module nios_system_pio_gen #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] START_DONE   = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [2:0]            start_cnt_q, start_cnt_d;

    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [DATA_WIDTH-1:0] sync_s;
    logic [DATA_WIDTH-1:0] edge_s;
    logic [DATA_WIDTH-1:0] clr_s;
    logic                  cap_en_s;
    logic [DATA_WIDTH-1:0] rd_s;
    logic                  unused_s;

    assign wr_en_s  = chipselect & ~write_n;
    assign wdata_s  = writedata[DATA_WIDTH-1:0];
    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign cap_en_s = (start_cnt_q == START_DONE);
    assign unused_s = &{1'b0, writedata};

    // Synchronizer chain shift and history flop
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_s;
    end

    // Edge detection according to the configured polarity
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_s = sync_s & ~prev_q;
            1:       edge_s = ~sync_s & prev_q;
            default: edge_s = sync_s ^ prev_q;
        endcase
    end

    // Startup counter saturates once the synchronizer holds real pin data
    always_comb begin
        if (cap_en_s) begin
            start_cnt_d = start_cnt_q;
        end else begin
            start_cnt_d = start_cnt_q + 3'd1;
        end
    end

    // Register writes; a capture in the same cycle as a clear keeps the bit set
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmask_d  = irqmask_q;
        clr_s      = {DATA_WIDTH{1'b0}};
        if (wr_en_s) begin
            case (address)
                ADDR_DATA:    data_out_d = wdata_s;
                ADDR_DIR:     dir_d      = wdata_s;
                ADDR_IRQMASK: irqmask_d  = wdata_s;
                ADDR_EDGECAP: clr_s      = wdata_s;
                ADDR_OUTSET:  data_out_d = data_out_q | wdata_s;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata_s;
                default:      data_out_d = data_out_q;
            endcase
        end else begin
            clr_s = {DATA_WIDTH{1'b0}};
        end
        if (cap_en_s) begin
            edgecap_d = (edgecap_q & ~clr_s) | edge_s;
        end else begin
            edgecap_d = edgecap_q & ~clr_s;
        end
    end

    // Read mux; DATA mixes driven and sensed bits by direction
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:    rd_s = (data_out_q & dir_q) | (sync_s & ~dir_q);
            ADDR_DIR:     rd_s = dir_q;
            ADDR_IRQMASK: rd_s = irqmask_q;
            ADDR_EDGECAP: rd_s = edgecap_q;
            default:      rd_s = {DATA_WIDTH{1'b0}};
        endcase
        readdata[DATA_WIDTH-1:0] = rd_s;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q  <= RESET_VALUE;
            dir_q       <= {DATA_WIDTH{1'b0}};
            irqmask_q   <= {DATA_WIDTH{1'b0}};
            edgecap_q   <= {DATA_WIDTH{1'b0}};
            prev_q      <= {DATA_WIDTH{1'b0}};
            sync_q      <= '0;
            start_cnt_q <= 3'd0;
        end else begin
            data_out_q  <= data_out_d;
            dir_q       <= dir_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            prev_q      <= prev_d;
            sync_q      <= sync_d;
            start_cnt_q <= start_cnt_d;
        end
    end

    assign out_port = data_out_q;
    assign oe       = dir_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_system_pio_gen.sv
// Bench for nios_system_pio_gen: four builds (8-bit rising with reset value,
// 8-bit any-edge, 32-bit, 1-bit) on a shared bus with per-build chipselect.
module tb_nios_system_pio_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic [3:0]  cs;
    logic        write_n;
    logic [31:0] writedata;

    logic [7:0]  in_a, out_a, oe_a;
    logic [7:0]  in_b, out_b, oe_b;
    logic [31:0] in_c, out_c, oe_c;
    logic        in_d, out_d, oe_d;
    logic        irq_a, irq_b, irq_c, irq_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;

    always #5 clk = ~clk;

    nios_system_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .readdata(rd_a), .in_port(in_a), .out_port(out_a), .oe(oe_a), .irq(irq_a));
    nios_system_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .readdata(rd_b), .in_port(in_b), .out_port(out_b), .oe(oe_b), .irq(irq_b));
    nios_system_pio_gen #(.DATA_WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .readdata(rd_c), .in_port(in_c), .out_port(out_c), .oe(oe_c), .irq(irq_c));
    nios_system_pio_gen #(.DATA_WIDTH(1), .RESET_VALUE(1'b0), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]), .write_n(write_n),
        .writedata(writedata), .readdata(rd_d), .in_port(in_d), .out_port(out_d), .oe(oe_d), .irq(irq_d));

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  in;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
        logic        exp_irq;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[14];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd;

    task automatic sb_push(string name, logic [31:0] exp);
        sb_q.push_back('{name, exp});
    endtask

    task automatic sb_check(logic [31:0] act);
        sb_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic bus_write(int dut, logic [2:0] a, logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs        = 4'b0001 << dut;
        @(posedge clk);
        #1;
        cs      = 4'b0000;
        write_n = 1'b1;
    endtask

    task automatic bus_read(int dut, logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cs      = 4'b0000;
        address = a;
        #1;
        case (dut)
            0:       d = rd_a;
            1:       d = rd_b;
            2:       d = rd_c;
            default: d = rd_d;
        endcase
    endtask

    task automatic read_check(int dut, logic [2:0] a, string name, logic [31:0] exp);
        logic [31:0] v;
        sb_push(name, exp);
        bus_read(dut, a, v);
        sb_check(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 32'h0000_000F, 8'h50, 32'h0F, 8'hA5, 8'h0F, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_00FF, 8'h50, 32'h5F, 8'hFF, 8'h0F, 1'b0};
        vecs[2]  = '{1'b1, 3'd5, 32'h0000_0003, 8'h50, 32'h00, 8'hFC, 8'h0F, 1'b0};
        vecs[3]  = '{1'b1, 3'd4, 32'h0000_0080, 8'h50, 32'h00, 8'hFC, 8'h0F, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 32'h0000_0000, 8'h50, 32'h5C, 8'hFC, 8'h0F, 1'b0};
        vecs[5]  = '{1'b0, 3'd3, 32'h0000_0000, 8'h50, 32'h40, 8'hFC, 8'h0F, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 32'hFFFF_FF12, 8'h50, 32'h52, 8'h12, 8'h0F, 1'b0};
        vecs[7]  = '{1'b1, 3'd6, 32'h0000_00FF, 8'h50, 32'h00, 8'h12, 8'h0F, 1'b0};
        vecs[8]  = '{1'b0, 3'd7, 32'h0000_0000, 8'h50, 32'h00, 8'h12, 8'h0F, 1'b0};
        vecs[9]  = '{1'b1, 3'd4, 32'h0000_0001, 8'h50, 32'h00, 8'h13, 8'h0F, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 32'h0000_0040, 8'h50, 32'h40, 8'h13, 8'h0F, 1'b1};
        vecs[11] = '{1'b1, 3'd2, 32'h0000_0000, 8'h50, 32'h00, 8'h13, 8'h0F, 1'b0};
        vecs[12] = '{1'b1, 3'd3, 32'h0000_0040, 8'h50, 32'h00, 8'h13, 8'h0F, 1'b0};
        vecs[13] = '{1'b1, 3'd1, 32'h0000_0000, 8'h50, 32'h00, 8'h13, 8'h00, 1'b0};

        reset_n   = 1'b0;
        cs        = 4'b0000;
        write_n   = 1'b1;
        address   = 3'd0;
        writedata = 32'd0;
        in_a      = 8'h3C;
        in_b      = 8'hFF;
        in_c      = 32'd0;
        in_d      = 1'b0;

        // Reset state, pins already high before release
        #12;
        sb_push("rst_out_a", 32'hA5); sb_check(out_a);
        sb_push("rst_oe_a", 32'h00);  sb_check(oe_a);
        sb_push("rst_irq_a", 32'h0);  sb_check(irq_a);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        read_check(0, 3'd0, "rst_rd_data_a", 32'h3C);
        for (int a = 1; a < 8; a++) begin
            read_check(0, 3'(a), $sformatf("rst_rd_a_addr%0d", a), 32'h0);
        end
        read_check(1, 3'd3, "startup_edgecap_b", 32'h0);

        // Table-driven register access on the 8-bit rising build
        for (int i = 0; i < 14; i++) begin
            sb_push($sformatf("vec%0d_rd", i), vecs[i].exp_rd);
            sb_push($sformatf("vec%0d_out", i), 32'(vecs[i].exp_out));
            sb_push($sformatf("vec%0d_oe", i), 32'(vecs[i].exp_oe));
            sb_push($sformatf("vec%0d_irq", i), 32'(vecs[i].exp_irq));
            in_a = vecs[i].in;
            if (vecs[i].wr) bus_write(0, vecs[i].addr, vecs[i].wdata);
            repeat (3) @(posedge clk);
            bus_read(0, vecs[i].addr, rd);
            sb_check(rd);
            sb_check(32'(out_a));
            sb_check(32'(oe_a));
            sb_check(32'(irq_a));
        end

        // Rising edge on bit 0: irq exactly on the third edge
        bus_write(0, 3'd2, 32'h01);
        @(negedge clk);
        in_a = 8'h51;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            sb_push($sformatf("latency_irq_edge%0d", e), (e == 3) ? 32'h1 : 32'h0);
            sb_check(32'(irq_a));
        end
        bus_write(0, 3'd3, 32'h01);
        sb_push("w1c_irq", 32'h0); sb_check(32'(irq_a));

        // Falling edge ignored; then capture coinciding with a clear
        @(negedge clk);
        in_a = 8'h50;
        repeat (5) @(posedge clk);
        read_check(0, 3'd3, "falling_ignored", 32'h0);
        @(negedge clk);
        in_a = 8'h51;
        @(posedge clk);
        @(posedge clk);
        bus_write(0, 3'd3, 32'h01);
        read_check(0, 3'd3, "set_wins_edgecap", 32'h01);
        sb_push("set_wins_irq", 32'h1); sb_check(32'(irq_a));
        bus_write(0, 3'd3, 32'h01);
        read_check(0, 3'd3, "clear_after_set", 32'h0);

        // Any-edge build: falling then rising pulse each captured
        @(negedge clk);
        in_b = 8'hFB;
        repeat (4) @(posedge clk);
        read_check(1, 3'd3, "any_fall_cap", 32'h04);
        bus_write(1, 3'd3, 32'h04);
        read_check(1, 3'd3, "any_cleared", 32'h0);
        @(negedge clk);
        in_b = 8'hFF;
        repeat (4) @(posedge clk);
        read_check(1, 3'd3, "any_rise_cap", 32'h04);
        bus_write(1, 3'd3, 32'h04);

        // 32-bit build
        bus_write(2, 3'd1, 32'hFFFF_FFFF);
        bus_write(2, 3'd0, 32'hDEAD_BEEF);
        read_check(2, 3'd0, "w32_rd_data", 32'hDEAD_BEEF);
        sb_push("w32_out", 32'hDEAD_BEEF); sb_check(out_c);
        sb_push("w32_oe", 32'hFFFF_FFFF);  sb_check(oe_c);
        bus_write(2, 3'd1, 32'h0);
        in_c = 32'h1234_5678;
        repeat (4) @(posedge clk);
        read_check(2, 3'd0, "w32_rd_in", 32'h1234_5678);

        // 1-bit build: upper writedata ignored, upper readdata zero
        bus_write(3, 3'd1, 32'hFFFF_FFFF);
        read_check(3, 3'd1, "w1_rd_dir", 32'h1);
        sb_push("w1_oe", 32'h1); sb_check(32'(oe_d));
        bus_write(3, 3'd0, 32'hFFFF_FFFE);
        sb_push("w1_out_zero", 32'h0); sb_check(32'(out_d));
        bus_write(3, 3'd4, 32'hFFFF_FFFE);
        sb_push("w1_outset_upper", 32'h0); sb_check(32'(out_d));
        bus_write(3, 3'd4, 32'h0000_0001);
        read_check(3, 3'd0, "w1_rd_data", 32'h1);
        read_check(3, 3'd4, "w1_rd_outset", 32'h0);

        // Reset with a capture pending discards it
        @(negedge clk);
        in_b = 8'hFB;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        sb_push("midrst_out_a", 32'hA5); sb_check(32'(out_a));
        sb_push("midrst_irq_a", 32'h0);  sb_check(32'(irq_a));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        read_check(1, 3'd3, "midrst_edgecap_b", 32'h0);
        read_check(0, 3'd3, "midrst_edgecap_a", 32'h0);
        read_check(0, 3'd1, "midrst_dir_a", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
